// File: rtl/branch_resolve_predictor.sv
// branch_resolve_predictor
// Resolves conditional branches in EX from the ALU flags and funct3. It also
// owns a direct-mapped table of 2-bit saturating counters: IF reads the
// table for a prediction, and EX retrains it.
// Optional feature macro: BRANCH_PERF_CNT_EN adds saturating branch and
// mispredict counters. When the macro is undefined, both counters read 0.
module branch_resolve_predictor #(
  parameter int         PC_W     = 32,
  parameter int         IDX_W    = 4,
  parameter logic [1:0] CTR_INIT = 2'b01,
  parameter int         CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [PC_W-1:0]  i_fetch_pc,
  output logic             o_pred_taken,
  input  logic             i_ex_valid,
  input  logic [PC_W-1:0]  i_ex_pc,
  input  logic             i_ex_pred_taken,
  input  logic [2:0]       i_funct_3,
  input  logic             i_z_flag,
  input  logic             i_s_flag,
  input  logic             i_v_flag,
  input  logic             i_c_flag,
  output logic             o_taken,
  output logic             o_mispredict,
  output logic             o_illegal_branch,
  output logic [CNT_W-1:0] o_branch_count,
  output logic [CNT_W-1:0] o_mispredict_count
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]       r_table [DEPTH];
  logic             r_illegal;
  logic [IDX_W-1:0] w_fetch_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic             w_legal;
  logic             w_cond;
  logic             w_update;
  logic [1:0]       w_ctr_cur;
  logic [1:0]       w_ctr_next;
  logic             w_unused_pc_bits;

  // Word-aligned PCs: bits [1:0] and the bits above the index do not select an entry.
  assign w_fetch_idx = i_fetch_pc[IDX_W+1:2];
  assign w_ex_idx    = i_ex_pc[IDX_W+1:2];
  assign w_unused_pc_bits = &{1'b0, i_fetch_pc[PC_W-1:IDX_W+2], i_fetch_pc[1:0],
                              i_ex_pc[PC_W-1:IDX_W+2], i_ex_pc[1:0]};

  // Branch condition decode; funct3 010/011 are reserved encodings.
  always_comb begin
    w_legal = 1'b1;
    w_cond  = 1'b0;
    case (i_funct_3)
      3'b000:  w_cond = i_z_flag;
      3'b001:  w_cond = ~i_z_flag;
      3'b100:  w_cond = i_s_flag ^ i_v_flag;
      3'b101:  w_cond = ~(i_s_flag ^ i_v_flag);
      3'b110:  w_cond = ~i_c_flag;
      3'b111:  w_cond = i_c_flag;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_update     = i_ex_valid & w_legal;
  assign o_taken      = w_update & w_cond;
  assign o_mispredict = w_update & (o_taken != i_ex_pred_taken);

  // Prediction is a plain combinational read of the pre-update table (no bypass).
  assign o_pred_taken = r_table[w_fetch_idx][1];

  // Next value for the counter being retrained, saturating at both ends.
  always_comb begin
    w_ctr_cur  = r_table[w_ex_idx];
    w_ctr_next = w_ctr_cur;
    if (o_taken) begin
      if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'b01;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'b01;
    end
  end

  // Counter table: reset to CTR_INIT, retrained on each legal resolved branch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= CTR_INIT;
    end else if (w_update) begin
      r_table[w_ex_idx] <= w_ctr_next;
    end
  end

  // One-cycle pulse flagging a branch that used a reserved funct3.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_illegal <= 1'b0;
    else          r_illegal <= i_ex_valid & ~w_legal;
  end

  assign o_illegal_branch = r_illegal;

`ifdef BRANCH_PERF_CNT_EN
  logic [CNT_W-1:0] r_branch_count;
  logic [CNT_W-1:0] r_mispredict_count;

  // Saturating performance counters; they stick at all-ones instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_update && !(&r_branch_count))
        r_branch_count <= r_branch_count + CNT_W'(1);
      if (o_mispredict && !(&r_mispredict_count))
        r_mispredict_count <= r_mispredict_count + CNT_W'(1);
    end
  end

  assign o_branch_count     = r_branch_count;
  assign o_mispredict_count = r_mispredict_count;
`else
  assign o_branch_count     = '0;
  assign o_mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_predictor.sv
// Directed testbench for branch_resolve_predictor. Expected values are
// hand-computed. It uses CNT_W=4 so that counter saturation can be reached.
module tb_branch_resolve_predictor;

  localparam int PC_W  = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [PC_W-1:0]  fetch_pc;
  logic             pred_taken;
  logic             ex_valid;
  logic [PC_W-1:0]  ex_pc;
  logic             ex_pred_taken;
  logic [2:0]       funct_3;
  logic             z_flag, s_flag, v_flag, c_flag;
  logic             taken, mispredict, illegal_branch;
  logic [CNT_W-1:0] branch_count, mispredict_count;

  int n_checks = 0;
  int n_fails  = 0;

  branch_resolve_predictor #(
    .PC_W(PC_W), .IDX_W(4), .CTR_INIT(2'b01), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_fetch_pc(fetch_pc),
    .o_pred_taken(pred_taken),
    .i_ex_valid(ex_valid),
    .i_ex_pc(ex_pc),
    .i_ex_pred_taken(ex_pred_taken),
    .i_funct_3(funct_3),
    .i_z_flag(z_flag),
    .i_s_flag(s_flag),
    .i_v_flag(v_flag),
    .i_c_flag(c_flag),
    .o_taken(taken),
    .o_mispredict(mispredict),
    .o_illegal_branch(illegal_branch),
    .o_branch_count(branch_count),
    .o_mispredict_count(mispredict_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected performance-counter value depends on whether the feature is built in.
  function automatic logic [31:0] exp_cnt(input int v);
`ifdef BRANCH_PERF_CNT_EN
    return 32'(v);
`else
    return 32'(v * 0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pred_chk(input string tag, input logic [31:0] pc, input logic exp);
    fetch_pc = pc;
    #1;
    chk(tag, {31'b0, pred_taken}, {31'b0, exp});
  endtask

  // One resolved branch: check the combinational outputs, then clock it in.
  task automatic br(input string tag, input logic [31:0] pc, input logic [2:0] f3,
                    input logic z, input logic s, input logic v, input logic c,
                    input logic p, input logic exp_t, input logic exp_m);
    ex_valid = 1'b1; ex_pc = pc; funct_3 = f3;
    z_flag = z; s_flag = s; v_flag = v; c_flag = c; ex_pred_taken = p;
    #2;
    chk({tag, "_taken"}, {31'b0, taken}, {31'b0, exp_t});
    chk({tag, "_misp"}, {31'b0, mispredict}, {31'b0, exp_m});
    step();
    ex_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; fetch_pc = 32'h40; ex_valid = 1'b0; ex_pc = '0;
    ex_pred_taken = 1'b0; funct_3 = 3'b000;
    z_flag = 1'b0; s_flag = 1'b0; v_flag = 1'b0; c_flag = 1'b0;

    // Reset state
    step(); step();
    pred_chk("rst_pred", 32'h40, 1'b0);
    chk("rst_illegal", {31'b0, illegal_branch}, 32'h0);
    chk("rst_bcnt", 32'(branch_count), 32'h0);
    chk("rst_mcnt", 32'(mispredict_count), 32'h0);
    #2 rst_n = 1'b1;
    step();

    // First BEQ at 0x40 mispredicted; the same-cycle prediction is still the old value
    fetch_pc = 32'h40;
    ex_valid = 1'b1; ex_pc = 32'h40; funct_3 = 3'b000; z_flag = 1'b1; ex_pred_taken = 1'b0;
    #2;
    chk("beq1_taken", {31'b0, taken}, 32'h1);
    chk("beq1_misp", {31'b0, mispredict}, 32'h1);
    chk("beq1_nobypass", {31'b0, pred_taken}, 32'h0);
    step();
    ex_valid = 1'b0;
    pred_chk("beq1_pred_after", 32'h40, 1'b1);          // counter 10
    chk("beq1_bcnt", 32'(branch_count), exp_cnt(1));
    chk("beq1_mcnt", 32'(mispredict_count), exp_cnt(1));

    // Three more taken: 10 -> 11 -> 11 -> 11
    br("beq2", 32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    br("beq3", 32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    br("beq4", 32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    pred_chk("sat_pred", 32'h40, 1'b1);
    // Two not-taken from saturation: 11 -> 10 -> 01
    br("nt1", 32'h40, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    pred_chk("nt1_pred", 32'h40, 1'b1);
    br("nt2", 32'h40, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    pred_chk("nt2_pred", 32'h40, 1'b0);
    chk("nt_bcnt", 32'(branch_count), exp_cnt(6));
    chk("nt_mcnt", 32'(mispredict_count), exp_cnt(3));

    // BNE both ways, then the signed and unsigned compares at distinct indices
    br("bne_nt", 32'h54, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    br("bne_t", 32'h58, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    br("blt", 32'h44, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    br("bge", 32'h48, 3'b101, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    br("bltu", 32'h4C, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    br("bgeu", 32'h50, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    pred_chk("blt_pred", 32'h44, 1'b1);                  // 01 -> 10
    pred_chk("bltu_pred", 32'h4C, 1'b0);                 // 01 -> 00
    pred_chk("alias_pred", 32'h80, 1'b0);                // aliases 0x40, counter 01
    chk("cmp_bcnt", 32'(branch_count), exp_cnt(12));
    chk("cmp_mcnt", 32'(mispredict_count), exp_cnt(5));

    // Reserved funct3: no resolution, no update, a one-cycle pulse next cycle
    ex_valid = 1'b1; ex_pc = 32'h40; funct_3 = 3'b010; z_flag = 1'b1; ex_pred_taken = 1'b1;
    #2;
    chk("ill_taken", {31'b0, taken}, 32'h0);
    chk("ill_misp", {31'b0, mispredict}, 32'h0);
    chk("ill_pulse_early", {31'b0, illegal_branch}, 32'h0);
    step();
    ex_valid = 1'b0;
    chk("ill_pulse", {31'b0, illegal_branch}, 32'h1);
    pred_chk("ill_no_update", 32'h40, 1'b0);
    step();
    chk("ill_pulse_end", {31'b0, illegal_branch}, 32'h0);
    br("ill011", 32'h44, 3'b011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ill011_pulse", {31'b0, illegal_branch}, 32'h1);

    // Ex_Valid low: nothing resolves and the table does not move
    funct_3 = 3'b000; z_flag = 1'b1; ex_pc = 32'h40; ex_pred_taken = 1'b0;
    #2;
    chk("nv_taken", {31'b0, taken}, 32'h0);
    chk("nv_misp", {31'b0, mispredict}, 32'h0);
    step();
    pred_chk("nv_pred", 32'h40, 1'b0);
    chk("nv_bcnt", 32'(branch_count), exp_cnt(12));

    // Train 0x40 up to 11, then assert reset mid-cycle: effect is immediate
    br("tr1", 32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    br("tr2", 32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    pred_chk("tr_pred", 32'h40, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pred", {31'b0, pred_taken}, 32'h0);
    chk("arst_bcnt", 32'(branch_count), 32'h0);
    chk("arst_mcnt", 32'(mispredict_count), 32'h0);
    pred_chk("arst_pred44", 32'h44, 1'b0);
    // A branch presented while reset is held must be discarded
    ex_valid = 1'b1; ex_pc = 32'h40; funct_3 = 3'b000; z_flag = 1'b1; ex_pred_taken = 1'b0;
    step();
    ex_valid = 1'b0;
    pred_chk("arst_discard", 32'h40, 1'b0);
    #2 rst_n = 1'b1;
    step();

    // 17 mispredicted taken branches: counters saturate at 15 with CNT_W=4
    for (int i = 0; i < 17; i++) begin
      ex_valid = 1'b1; ex_pc = 32'h60; funct_3 = 3'b000; z_flag = 1'b1; ex_pred_taken = 1'b0;
      step();
    end
    ex_valid = 1'b0;
    chk("sat_bcnt", 32'(branch_count), exp_cnt(15));
    chk("sat_mcnt", 32'(mispredict_count), exp_cnt(15));
    pred_chk("sat60_pred", 32'h60, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
